// File: rtl/eth_pcs_pkg.sv
// Shared 10G PCS RX definitions: sync header encodings, lock FSM states, default limits.
package eth_pcs_pkg;

  localparam int unsigned W_SYNC          = 2;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  localparam int unsigned SH_WINDOW_DEF   = 64;
  localparam int unsigned SH_BAD_MAX_DEF  = 16;
  localparam int unsigned SLIP_WAIT_DEF   = 4;
  localparam int unsigned BER_WINDOW_DEF  = 19531;
  localparam int unsigned HI_BER_BAD      = 16;

  typedef enum logic [1:0] {
    ST_RESET_CNT,
    ST_TEST,
    ST_SLIP,
    ST_SLIP_WAIT
  } lock_state_t;

  function automatic logic sync_hdr_ok(input logic [W_SYNC-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_block_lock_if.sv
// Gearbox <-> block-lock link: header stream in, slip request and status flags out.
interface eth_pcs_rx_block_lock_if
  import eth_pcs_pkg::*;
();

  logic              i_clk_en;
  logic              i_hdr_valid;
  logic [W_SYNC-1:0] i_hdr;
  logic              o_slip;
  logic              o_block_lock;
  logic              o_hi_ber;

  modport master (
    output i_clk_en,
    output i_hdr_valid,
    output i_hdr,
    input  o_slip,
    input  o_block_lock,
    input  o_hi_ber
  );

  modport slave (
    input  i_clk_en,
    input  i_hdr_valid,
    input  i_hdr,
    output o_slip,
    output o_block_lock,
    output o_hi_ber
  );

endinterface

// File: rtl/eth_pcs_rx_ber_mon.sv
// Hi-BER monitor: counts invalid sync headers over fixed header windows while block lock holds.
module eth_pcs_rx_ber_mon
  import eth_pcs_pkg::*;
#(
  parameter int unsigned BER_WINDOW = BER_WINDOW_DEF
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_qual,
  input  logic i_hdr_ok,
  input  logic i_block_lock,
  output logic o_hi_ber
);

  localparam int unsigned WW = $clog2(BER_WINDOW + 1);
  localparam logic [WW-1:0] WIN_LIM = WW'(BER_WINDOW);
  localparam logic [4:0]    BAD_LIM = 5'(HI_BER_BAD);

  logic [WW-1:0] r_win_cnt;
  logic [4:0]    r_bad_cnt;
  logic          r_hi_ber;

  logic [WW-1:0] w_win_inc;
  logic [4:0]    w_bad_nxt;
  logic          w_bad_hit;

  assign w_win_inc = r_win_cnt + WW'(1);
  assign w_bad_nxt = (!i_hdr_ok && (r_bad_cnt != BAD_LIM)) ? r_bad_cnt + 5'd1 : r_bad_cnt;
  assign w_bad_hit = (w_bad_nxt == BAD_LIM);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_win_cnt <= '0;
      r_bad_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (!i_block_lock) begin
      r_win_cnt <= '0;
      r_bad_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (i_qual) begin
      if (w_win_inc == WIN_LIM) begin
        // window boundary: flag reflects whether this window reached the limit
        r_win_cnt <= '0;
        r_bad_cnt <= '0;
        r_hi_ber  <= w_bad_hit;
      end else begin
        r_win_cnt <= w_win_inc;
        r_bad_cnt <= w_bad_nxt;
        if (w_bad_hit) r_hi_ber <= 1'b1;
      end
    end
  end

  assign o_hi_ber = r_hi_ber;

endmodule

// File: rtl/eth_pcs_rx_block_lock.sv
// 66b block-lock FSM with gearbox slip control. Hi-BER monitor built only with ETH_PCS_RX_HI_BER_EN.
module eth_pcs_rx_block_lock
  import eth_pcs_pkg::*;
#(
`ifdef ETH_PCS_RX_HI_BER_EN
  parameter int unsigned BER_WINDOW = BER_WINDOW_DEF,
`endif
  parameter int unsigned SH_WINDOW  = SH_WINDOW_DEF,
  parameter int unsigned SH_BAD_MAX = SH_BAD_MAX_DEF,
  parameter int unsigned SLIP_WAIT  = SLIP_WAIT_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  eth_pcs_rx_block_lock_if.slave  bus
);

  localparam int unsigned WAIT_W   = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;
  localparam logic [6:0]        SH_LIM   = 7'(SH_WINDOW);
  localparam logic [4:0]        BAD_LIM  = 5'(SH_BAD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(SLIP_WAIT);

  lock_state_t       r_state,    w_state_nxt;
  logic [6:0]        r_sh_cnt,   w_sh_nxt;
  logic [4:0]        r_bad_cnt,  w_bad_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic              r_slip,     w_slip_nxt;
  logic              r_lock,     w_lock_nxt;

  logic              w_qual;
  logic              w_hdr_ok;
  logic [6:0]        w_sh_inc;
  logic [4:0]        w_bad_inc;
  logic [WAIT_W-1:0] w_wait_inc;

  assign w_qual     = bus.i_clk_en & bus.i_hdr_valid;
  assign w_hdr_ok   = sync_hdr_ok(bus.i_hdr);
  assign w_sh_inc   = (r_sh_cnt   == SH_LIM)   ? r_sh_cnt   : r_sh_cnt + 7'd1;
  assign w_bad_inc  = (r_bad_cnt  == BAD_LIM)  ? r_bad_cnt  : r_bad_cnt + 5'd1;
  assign w_wait_inc = (r_wait_cnt == WAIT_LIM) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_RESET_CNT;
      r_sh_cnt   <= '0;
      r_bad_cnt  <= '0;
      r_wait_cnt <= '0;
      r_slip     <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sh_cnt   <= w_sh_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_slip     <= w_slip_nxt;
      r_lock     <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_slip_nxt  = 1'b0;
    w_lock_nxt  = r_lock;

    unique case (r_state)
      ST_RESET_CNT: begin
        w_sh_nxt    = '0;
        w_bad_nxt   = '0;
        w_state_nxt = ST_TEST;
      end

      ST_TEST: begin
        if (w_qual) begin
          w_sh_nxt  = w_sh_inc;
          w_bad_nxt = w_hdr_ok ? r_bad_cnt : w_bad_inc;
          // bad-count check precedes the window check so it wins on a shared header
          if (!w_hdr_ok && !r_lock) begin
            w_slip_nxt  = 1'b1;
            w_state_nxt = ST_SLIP;
          end else if (r_lock && (w_bad_nxt == BAD_LIM)) begin
            w_lock_nxt  = 1'b0;
            w_slip_nxt  = 1'b1;
            w_state_nxt = ST_SLIP;
          end else if (w_sh_nxt == SH_LIM) begin
            if (w_bad_nxt == '0) w_lock_nxt = 1'b1;
            w_state_nxt = ST_RESET_CNT;
          end
        end
      end

      ST_SLIP: begin
        w_wait_nxt  = '0;
        w_state_nxt = ST_SLIP_WAIT;
      end

      ST_SLIP_WAIT: begin
        if (w_qual) begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc >= WAIT_LIM) w_state_nxt = ST_RESET_CNT;
        end
      end

      default: w_state_nxt = ST_RESET_CNT;
    endcase
  end

  assign bus.o_slip       = r_slip;
  assign bus.o_block_lock = r_lock;

`ifdef ETH_PCS_RX_HI_BER_EN
  eth_pcs_rx_ber_mon #(
    .BER_WINDOW (BER_WINDOW)
  ) u_ber_mon (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_qual       (w_qual),
    .i_hdr_ok     (w_hdr_ok),
    .i_block_lock (r_lock),
    .o_hi_ber     (bus.o_hi_ber)
  );
`else
  assign bus.o_hi_ber = 1'b0;
`endif

endmodule
